// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions: control-group widths, bit positions and the
// ID/EX per-edge action encoding used by decode and the later stages.
package id_ex_stage_pkg;

  localparam int WB_W  = 2;
  localparam int MEM_W = 3;
  localparam int EX_W  = 4;

  localparam int WB_MEMTOREG = 1;
  localparam int WB_REGWRITE = 0;

  localparam int MEM_READ   = 2;
  localparam int MEM_WRITE  = 1;
  localparam int MEM_BRANCH = 0;

  localparam int EX_ALUOP_MSB = 3;
  localparam int EX_ALUOP_LSB = 2;
  localparam int EX_ALUSRC    = 1;
  localparam int EX_REGDST    = 0;

  localparam int CNT_W = 16;

  typedef logic [WB_W-1:0]  wb_ctrl_t;
  typedef logic [MEM_W-1:0] mem_ctrl_t;
  typedef logic [EX_W-1:0]  ex_ctrl_t;

  typedef struct packed {
    wb_ctrl_t  wb;
    mem_ctrl_t mem;
    ex_ctrl_t  ex;
  } ctrl_t;

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_HOLD   = 2'd2,
    ACT_FLUSH  = 2'd3
  } stage_act_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bus: decode-side inputs, registered execute-side outputs
// and the stall/bubble-count status returned to the front end.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  import id_ex_stage_pkg::*;

  wb_ctrl_t          i_sig_wb;
  mem_ctrl_t         i_sig_mem;
  ex_ctrl_t          i_sig_ex;
  logic [DATA_W-1:0] i_rd1;
  logic [DATA_W-1:0] i_rd2;
  logic [DATA_W-1:0] i_sext;
  logic [DATA_W-1:0] i_npc;
  logic [REG_W-1:0]  i_rs;
  logic [REG_W-1:0]  i_rt;
  logic [REG_W-1:0]  i_rd;
  logic              i_flush;
  logic              i_hold;

  wb_ctrl_t          o_sig_wb;
  mem_ctrl_t         o_sig_mem;
  ex_ctrl_t          o_sig_ex;
  logic [DATA_W-1:0] o_rd1;
  logic [DATA_W-1:0] o_rd2;
  logic [DATA_W-1:0] o_sext;
  logic [DATA_W-1:0] o_npc;
  logic [REG_W-1:0]  o_rs;
  logic [REG_W-1:0]  o_rt;
  logic [REG_W-1:0]  o_rd;
  logic              o_valid;
  logic              o_stall;
  logic [CNT_W-1:0]  o_bubble_cnt;

  modport master (
    output i_sig_wb, i_sig_mem, i_sig_ex, i_rd1, i_rd2, i_sext, i_npc,
           i_rs, i_rt, i_rd, i_flush, i_hold,
    input  o_sig_wb, o_sig_mem, o_sig_ex, o_rd1, o_rd2, o_sext, o_npc,
           o_rs, o_rt, o_rd, o_valid, o_stall, o_bubble_cnt
  );

  modport slave (
    input  i_sig_wb, i_sig_mem, i_sig_ex, i_rd1, i_rd2, i_sext, i_npc,
           i_rs, i_rt, i_rd, i_flush, i_hold,
    output o_sig_wb, o_sig_mem, o_sig_ex, o_rd1, o_rd2, o_sext, o_npc,
           o_rs, o_rt, o_rd, o_valid, o_stall, o_bubble_cnt
  );

endinterface

// File: rtl/id_ex_stage_hazard.sv
// Load-use hazard compare between the load sitting in EX and the decode slot.
// Purely combinational; register 0 is hard-wired and never conflicts.
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             hazard
);

  assign hazard = ex_valid & ex_mem_read & (ex_rt != '0)
                & ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush, hold and load-use bubble insertion.
// One action per edge (flush > hold > hazard > load); bubbles are counted, saturating.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input logic          clk,
  input logic          rstn,
  id_ex_stage_if.slave bus
);

  ctrl_t             ctrl_q;
  logic              valid_q;
  logic [DATA_W-1:0] rd1_q;
  logic [DATA_W-1:0] rd2_q;
  logic [DATA_W-1:0] sext_q;
  logic [DATA_W-1:0] npc_q;
  logic [REG_W-1:0]  rs_q;
  logic [REG_W-1:0]  rt_q;
  logic [REG_W-1:0]  rd_q;
  logic [CNT_W-1:0]  bubble_cnt;
  logic              hazard;
  stage_act_e        act;

  hazard_detect #(
    .REG_W(REG_W)
  ) u_hazard (
    .ex_valid   (valid_q),
    .ex_mem_read(ctrl_q.mem[MEM_READ]),
    .ex_rt      (rt_q),
    .id_rs      (bus.i_rs),
    .id_rt      (bus.i_rt),
    .hazard     (hazard)
  );

  always_comb begin
    act = ACT_LOAD;
    if (bus.i_flush) begin
      act = ACT_FLUSH;
    end else if (bus.i_hold) begin
      act = ACT_HOLD;
    end else if (hazard) begin
      act = ACT_BUBBLE;
    end
  end

  // A flush already kills the decode slot, so a coincident hazard needs no stall.
  assign bus.o_stall = bus.i_hold | (hazard & ~bus.i_flush);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl_q     <= '0;
      valid_q    <= 1'b0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      sext_q     <= '0;
      npc_q      <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      bubble_cnt <= '0;
    end else begin
      case (act)
        ACT_FLUSH: begin
          ctrl_q  <= '0;
          valid_q <= 1'b0;
        end
        ACT_BUBBLE: begin
          ctrl_q     <= '0;
          valid_q    <= 1'b0;
          bubble_cnt <= sat_inc(bubble_cnt);
        end
        ACT_LOAD: begin
          ctrl_q  <= {bus.i_sig_wb, bus.i_sig_mem, bus.i_sig_ex};
          valid_q <= 1'b1;
          rd1_q   <= bus.i_rd1;
          rd2_q   <= bus.i_rd2;
          sext_q  <= bus.i_sext;
          npc_q   <= bus.i_npc;
          rs_q    <= bus.i_rs;
          rt_q    <= bus.i_rt;
          rd_q    <= bus.i_rd;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.o_sig_wb     = ctrl_q.wb;
  assign bus.o_sig_mem    = ctrl_q.mem;
  assign bus.o_sig_ex     = ctrl_q.ex;
  assign bus.o_valid      = valid_q;
  assign bus.o_rd1        = rd1_q;
  assign bus.o_rd2        = rd2_q;
  assign bus.o_sext       = sext_q;
  assign bus.o_npc        = npc_q;
  assign bus.o_rs         = rs_q;
  assign bus.o_rt         = rt_q;
  assign bus.o_rd         = rd_q;
  assign bus.o_bubble_cnt = bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed hazard/flush/hold/reset cases,
// then random traffic against an instruction-level reference model.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int DW = 32;
  localparam int RW = 5;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(DW), .REG_W(RW)) bus ();
  id_ex_stage #(.DATA_W(DW), .REG_W(RW)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  typedef struct {
    logic [1:0]  wb;
    logic [2:0]  mem;
    logic [3:0]  ex;
    logic [31:0] rd1, rd2, sext, npc;
    logic [4:0]  rs, rt, rd;
    logic        flush, hold;
  } stim_t;

  typedef struct {
    logic        stall;
    logic        valid;
    stim_t       slot;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  stim_t       m_slot;
  logic        m_valid;
  int unsigned m_bubbles;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, req);
    end
  endtask

  function automatic stim_t blank();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t rnd_data(input stim_t b);
    stim_t s = b;
    s.rd1  = $urandom();
    s.rd2  = $urandom();
    s.sext = $urandom();
    s.npc  = $urandom();
    s.rd   = 5'($urandom_range(0, 31));
    return s;
  endfunction

  task automatic model_reset();
    m_slot    = blank();
    m_valid   = 1'b0;
    m_bubbles = 0;
  endtask

  // Drive the decode slot and predict stall plus the stage contents after the next edge.
  task automatic issue(input stim_t s);
    exp_t e;
    logic haz;
    bus.i_sig_wb  = s.wb;   bus.i_sig_mem = s.mem;  bus.i_sig_ex = s.ex;
    bus.i_rd1     = s.rd1;  bus.i_rd2     = s.rd2;
    bus.i_sext    = s.sext; bus.i_npc     = s.npc;
    bus.i_rs      = s.rs;   bus.i_rt      = s.rt;   bus.i_rd     = s.rd;
    bus.i_flush   = s.flush; bus.i_hold   = s.hold;
    haz = m_valid && m_slot.mem[2] && (m_slot.rt != 0)
       && ((m_slot.rt == s.rs) || (m_slot.rt == s.rt));
    e.stall = s.hold || (haz && !s.flush);
    if (s.flush || (!s.hold && haz)) begin
      m_valid    = 1'b0;
      m_slot.wb  = '0;
      m_slot.mem = '0;
      m_slot.ex  = '0;
      if (!s.flush) m_bubbles++;
    end else if (!s.hold) begin
      m_slot  = s;
      m_valid = 1'b1;
    end
    e.valid = m_valid;
    e.slot  = m_slot;
    e.cnt   = (m_bubbles > 65535) ? 16'hFFFF : 16'(m_bubbles);
    exp_q.push_back(e);
  endtask

  task automatic step(input stim_t s);
    @(negedge clk);
    issue(s);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.o_valid),      32'd0);
    chk({tag, "_cnt"},   32'(bus.o_bubble_cnt), 32'd0);
    chk({tag, "_wb"},    32'(bus.o_sig_wb),     32'd0);
    chk({tag, "_mem"},   32'(bus.o_sig_mem),    32'd0);
    chk({tag, "_ex"},    32'(bus.o_sig_ex),     32'd0);
    chk({tag, "_rd1"},   bus.o_rd1,             32'd0);
    chk({tag, "_rd2"},   bus.o_rd2,             32'd0);
    chk({tag, "_sext"},  bus.o_sext,            32'd0);
    chk({tag, "_npc"},   bus.o_npc,             32'd0);
    chk({tag, "_idx"},   32'({bus.o_rs, bus.o_rt, bus.o_rd}), 32'd0);
  endtask

  // Monitor: stall is checked mid-cycle, the registered slot just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        chk("stall", 32'(bus.o_stall), 32'(e.stall));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("valid", 32'(bus.o_valid),      32'(e.valid));
        chk("cnt",   32'(bus.o_bubble_cnt), 32'(e.cnt));
        chk("ctrl",  32'({bus.o_sig_wb, bus.o_sig_mem, bus.o_sig_ex}),
                     32'({e.slot.wb, e.slot.mem, e.slot.ex}));
        if (e.valid) begin
          chk("rd1",  bus.o_rd1,  e.slot.rd1);
          chk("rd2",  bus.o_rd2,  e.slot.rd2);
          chk("sext", bus.o_sext, e.slot.sext);
          chk("npc",  bus.o_npc,  e.slot.npc);
          chk("idx",  32'({bus.o_rs, bus.o_rt, bus.o_rd}),
                      32'({e.slot.rs, e.slot.rt, e.slot.rd}));
        end
      end
    end
  end

  initial begin
    stim_t s, lw;
    issue_idle: begin
      bus.i_sig_wb = '0; bus.i_sig_mem = '0; bus.i_sig_ex = '0;
      bus.i_rd1 = '0; bus.i_rd2 = '0; bus.i_sext = '0; bus.i_npc = '0;
      bus.i_rs = '0; bus.i_rt = '0; bus.i_rd = '0;
      bus.i_flush = 1'b0; bus.i_hold = 1'b0;
    end
    #1 rstn = 1'b0;
    #1 check_zero("por");
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    model_reset();

    // Plain load
    s = blank(); s.ex = 4'b1001; s.rd1 = 32'h12345678; s.rs = 5'd1; s.rt = 5'd2;
    step(s);

    // Load-use: bubble once, then the same decode instruction loads
    lw = rnd_data(blank()); lw.mem = 3'b100; lw.wb = 2'b11; lw.rs = 5'd1; lw.rt = 5'd5;
    step(lw);
    s = rnd_data(blank()); s.rs = 5'd5; s.rt = 5'd2; s.wb = 2'b01; s.ex = 4'b0010;
    step(s);
    step(s);

    // Asynchronous reset between edges with the stage loaded
    @(posedge clk);
    #3 rstn = 1'b0;
    #1 check_zero("mid_rst");
    #1 rstn = 1'b1;
    model_reset();

    // Register 0 load followed by a $zero consumer: no hazard
    lw = rnd_data(blank()); lw.mem = 3'b100; lw.rt = 5'd0;
    step(lw);
    s = rnd_data(blank()); s.rs = 5'd0; s.rt = 5'd0; s.ex = 4'b0100;
    step(s);

    // Flush coinciding with a hazard: no stall, bubble not counted
    lw = rnd_data(blank()); lw.mem = 3'b100; lw.rt = 5'd7;
    step(lw);
    s = rnd_data(blank()); s.rs = 5'd7; s.flush = 1'b1; s.wb = 2'b10;
    step(s);
    s.flush = 1'b0;
    step(s);

    // Hold for three cycles over a pending hazard, then the hazard resolves
    lw = rnd_data(blank()); lw.mem = 3'b110; lw.rt = 5'd3; lw.ex = 4'b1111;
    step(lw);
    for (int i = 0; i < 3; i++) begin
      s = rnd_data(blank()); s.rs = 5'd3; s.hold = 1'b1; s.ex = 4'b0001;
      step(s);
    end
    s.hold = 1'b0;
    step(s);

    // Saturation: preload the counter just below full
    lw = rnd_data(blank()); lw.mem = 3'b100; lw.rt = 5'd4;
    step(lw);
    @(negedge clk);
    force dut.bubble_cnt = 16'hFFFE;
    #1 release dut.bubble_cnt;
    m_bubbles = 65534;
    s = rnd_data(blank()); s.mem = 3'b100; s.rs = 5'd4; s.rt = 5'd4;
    issue(s);
    step(s);
    step(s);

    // Random traffic on a small register window so hazards are frequent
    for (int i = 0; i < 600; i++) begin
      s = rnd_data(blank());
      s.wb    = 2'($urandom_range(0, 3));
      s.mem   = 3'($urandom_range(0, 7));
      s.ex    = 4'($urandom_range(0, 15));
      s.rs    = 5'($urandom_range(0, 3));
      s.rt    = 5'($urandom_range(0, 3));
      s.flush = ($urandom_range(0, 9) == 0);
      s.hold  = ($urandom_range(0, 7) == 0);
      step(s);
    end

    @(posedge clk);
    #3;
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width.
REQ-002 SHALL have parameter REG_W, default 5, register-index width.
REQ-003 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have i_sig_wb  input  2  decode WB controls: [1] MemtoReg, [0] RegWrite.
REQ-006 SHALL have i_sig_mem  input  3  decode MEM controls: [2] MemRead, [1] MemWrite, [0] Branch.
REQ-007 SHALL have i_sig_ex  input  4  decode EX controls: [3:2] ALUOp, [1] ALUSrc, [0] RegDst.
REQ-008 SHALL have i_rd1, i_rd2, i_sext, i_npc  input  DATA_W each  register reads, sign-extended immediate, next PC.
REQ-009 SHALL have i_rs, i_rt, i_rd  input  REG_W each  instruction fields [25:21], [20:16], [15:11].
REQ-010 SHALL have i_flush  input  1  branch taken in MEM; squash decode slot.
REQ-011 SHALL have i_hold  input  1  downstream busy; freeze stage.
REQ-012 SHALL have o_sig_wb/o_sig_mem/o_sig_ex, o_rd1/o_rd2/o_sext/o_npc, o_rs/o_rt/o_rd  output  same widths  registered copies.
REQ-013 SHALL have o_valid  output  1  registered slot holds a real instruction.
REQ-014 SHALL have o_stall  output  1  combinational; freeze PC and IF/ID this cycle.
REQ-015 SHALL have o_bubble_cnt  output  16  count of inserted bubbles.

Function
REQ-016 SHALL detect load-use hazard when o_valid=1, o_sig_mem[2]=1, o_rt!=0, and (o_rt==i_rs or o_rt==i_rt).
REQ-017 SHALL drive o_stall = i_hold | (hazard & ~i_flush).
REQ-018 SHALL, per edge, apply exactly one action, priority flush > hold > hazard > load.
REQ-019 flush SHALL clear all three control groups and o_valid; data/index registers don't-care.
REQ-020 hold SHALL retain every register unchanged, including o_valid and o_bubble_cnt.
REQ-021 hazard SHALL clear control groups and o_valid (bubble) and increment o_bubble_cnt.
REQ-022 load SHALL capture all inputs with one-cycle latency and set o_valid=1.
REQ-023 o_bubble_cnt SHALL saturate at 16'hFFFF; only hazard bubbles count, not flushes.
REQ-024 A hazard SHALL last exactly one cycle per load: after the bubble, o_valid=0, so the same decode instruction loads on the next edge.
REQ-025 With flush and hazard together, the flush bubble SHALL be inserted, o_stall SHALL be 0, and the counter SHALL not change.
REQ-026 Register 0 SHALL never cause a hazard.

Reset
REQ-027 On rstn low, all outputs SHALL clear to 0 immediately, regardless of clk.
REQ-028 After rstn deasserts mid-operation, the first edge SHALL act as normal load; no in-flight state is retained.

Structure
REQ-029 Control-field bit positions (WB/MEM/EX indices) and widths SHALL live in the shared pipeline package used by decode and later stages.
REQ-030 Hazard comparison SHALL be a sub-module hazard_detect that is purely combinational; the pipeline register and counter stay in id_ex_stage.

Verification
REQ-031 Reset: assert rstn=0 between edges with registers loaded -> all outputs 0 before next edge.
REQ-032 Normal flow: i_sig_ex=4'b1001, i_rd1=32'h12345678, no hazard -> next edge o_sig_ex=4'b1001, o_rd1=32'h12345678, o_valid=1, o_stall=0.
REQ-033 Load-use: EX holds lw with o_rt=5 and o_sig_mem=3'b100; decode i_rs=5 -> o_stall=1, next edge o_valid=0, controls 0, o_bubble_cnt=1; following edge loads decode, o_valid=1.
REQ-034 Zero register: EX lw with o_rt=0, decode i_rs=0 -> o_stall=0, normal load.
REQ-035 Flush vs hazard: hazard condition plus i_flush=1 -> o_stall=0, bubble inserted, o_bubble_cnt unchanged.
REQ-036 Hold and saturation: i_hold=1 for 3 cycles -> all outputs constant, o_stall=1; preload counter to 16'hFFFF, force hazard -> stays 16'hFFFF.
